lsu_load_unit: RTL and testbench
================================

// Module: lsu_load_unit
// PURPOSE
//   Parametrised load-return path of the LSU. Selects one of N_SRC read sources
//   (input buffer, output buffer, data memory, ...), waits MEM_LAT cycles for the
//   data-memory source, then extracts and extends the byte/half/word for the load.
//   Sits between the LSU address decode and the register-file write-back mux.
//   Registered result with a one-cycle valid pulse; o_busy stalls the pipeline.
// PARAMETERS
//   XLEN     32  data/address width (>=32, multiple of 8)
//   N_SRC    4   number of read sources (>=2); unused encodings return 0
//   MEM_SRC  2   index of the latency-bearing (data memory) source
//   MEM_LAT  2   data-memory read latency in cycles (0 = combinational like others)
// PORTS
//   i_clk        in   1             clock, all state on rising edge
//   i_reset      in   1             synchronous, active-high reset
//   i_ld_req     in   1             load request, sampled only when o_busy=0
//   i_ld_addr    in   XLEN          byte address; [1:0] select lane
//   i_ld_funct3  in   3             000 LB,001 LH,010 LW,100 LBU,101 LHU
//   i_src_sel    in   $clog2(N_SRC) source index for this request
//   i_src_data   in   N_SRC*XLEN    flat source words, source k at [k*XLEN +: XLEN]
//   o_ld_data    out  XLEN          registered extended load result
//   o_ld_valid   out  1             1-cycle pulse, o_ld_data/o_ld_err valid
//   o_ld_err     out  1             illegal funct3 (or misaligned, see CONFIG)
//   o_busy       out  1             1 while in WAIT; requests ignored
// BEHAVIOUR
//   Reset: state=IDLE, counter=0, o_ld_data=0, o_ld_valid=0, o_ld_err=0.
//   o_busy = (state==WAIT), combinational from state.
//   FSM IDLE: req & (src!=MEM_SRC | MEM_LAT==0 | err) -> capture this edge, stay IDLE;
//     req & src==MEM_SRC & MEM_LAT>0 & !err -> latch addr/funct3/sel, cnt=MEM_LAT-1, WAIT.
//   FSM WAIT: cnt!=0 -> cnt--; cnt==0 -> capture from i_src_data[MEM_SRC], IDLE.
//   Latency: non-memory load valid 1 cycle after req; memory load MEM_LAT+1 cycles.
//   Back-to-back: non-memory requests accepted every cycle; new req allowed in the
//     cycle o_ld_valid is high. Capture edge pulses o_ld_valid=1, else 0.
//   Capture for WAIT uses latched addr/funct3/sel; i_ld_* ignored while busy.
//   Extraction (little-endian): LB/LBU byte at addr[1:0]; LH/LHU half at addr[1];
//     LW full word. LB/LH sign-extend to XLEN, LBU/LHU zero-extend.
//   Illegal funct3 (011,110,111): o_ld_data=0, o_ld_err=1, no WAIT even for MEM_SRC.
//   i_src_sel >= N_SRC: o_ld_data=0, o_ld_err=0, still pulses o_ld_valid.
//   Reset mid-WAIT: return IDLE, pending load dropped, no valid pulse.
// CONFIGURATION
//   LSU_MISALIGN_CHECK_EN defined: LH/LHU with addr[0]=1 or LW with addr[1:0]!=0
//     -> o_ld_err=1, o_ld_data=0, treated as error (no WAIT), valid next cycle.
//   Not defined: no alignment check; LH uses addr[1] only, LW ignores addr[1:0];
//     o_ld_err reports illegal funct3 only.
// TESTING
//   Reset -> all outputs 0; src0=0x1234_5678, LW addr 0x0 sel0 -> next cycle data 0x12345678, valid=1.
//   MEM_LAT=2, src2=0x0000_80F0, LH addr 0x0 sel2 -> busy 2 cycles, valid on cycle 3, data 0xFFFF80F0.
//   LBU addr 0x3 src1=0xAB00_0000 then LB same, consecutive cycles -> 0x000000AB, then 0xFFFFFFAB.
//   funct3=011 -> data 0, err=1, valid 1 cycle later; sel=5 with N_SRC=4 -> data 0, err 0.
//   Mem load then i_reset at WAIT cycle 1 -> IDLE, busy=0, no valid pulse ever.
//   LW addr 0x2: with LSU_MISALIGN_CHECK_EN -> err=1 data 0; without -> full word, err 0.

Source files
------------

// File: rtl/lsu_load_unit.sv
// Load-return path of the LSU.
//
// Picks one of N_SRC read-source words, waits MEM_LAT cycles when the request
// targets the data-memory source (MEM_SRC), then extracts and sign/zero-extends
// the byte, half or word. The result is registered and comes with a one-cycle
// o_ld_valid pulse. While a memory load is waiting, o_busy is high and new
// requests are ignored.
//
// Optional feature: define LSU_MISALIGN_CHECK_EN to flag misaligned LH/LHU/LW
// as errors. In the default build only illegal funct3 values raise o_ld_err.
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_reset      synchronous active-high reset
//   i_ld_req     load request, sampled only while o_busy = 0
//   i_ld_addr    byte address, [1:0] selects the lane
//   i_ld_funct3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   i_src_sel    source index for this request
//   i_src_data   flat source words, source k at [k*XLEN +: XLEN]
//   o_ld_data    registered extended load result
//   o_ld_valid   one-cycle pulse qualifying o_ld_data / o_ld_err
//   o_ld_err     illegal funct3 (or misaligned when the check is enabled)
//   o_busy       high while a memory load is waiting
module lsu_load_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned MEM_SRC = 2,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_ld_req,
  input  logic [XLEN-1:0]          i_ld_addr,
  input  logic [2:0]               i_ld_funct3,
  input  logic [$clog2(N_SRC)-1:0] i_src_sel,
  input  logic [N_SRC*XLEN-1:0]    i_src_data,
  output logic [XLEN-1:0]          o_ld_data,
  output logic                     o_ld_valid,
  output logic                     o_ld_err,
  output logic                     o_busy
);

  localparam int unsigned SelW = $clog2(N_SRC);
  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned CntLoad = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;

  typedef enum logic {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  // Only the lane bits of the address matter to extraction.
  logic unused_addr;
  assign unused_addr = ^i_ld_addr[XLEN-1:2];

  logic            is_wait;
  logic [1:0]      cur_lane;
  logic [2:0]      cur_f3;
  logic [SelW-1:0] cur_sel;
  logic [XLEN-1:0] word;
  logic            sel_ok;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] ext;
  logic            illegal;
  logic            misalign;
  logic            err_c;
  logic [XLEN-1:0] result;

  // In WAIT the latched request is replayed against the memory source.
  always_comb begin
    is_wait  = (state_q == StWait);
    cur_lane = is_wait ? lane_q : i_ld_addr[1:0];
    cur_f3   = is_wait ? f3_q : i_ld_funct3;
    cur_sel  = is_wait ? SelW'(MEM_SRC) : i_src_sel;

    word = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (cur_sel == SelW'(k)) word = i_src_data[k*XLEN +: XLEN];
    end
    sel_ok = (32'(cur_sel) < N_SRC);

    unique case (cur_lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = cur_lane[1] ? word[31:16] : word[15:0];

    case (cur_f3)
      3'b000:  ext = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b001:  ext = {{(XLEN-16){half_v[15]}}, half_v};
      3'b010:  ext = word;
      3'b100:  ext = {{(XLEN-8){1'b0}}, byte_v};
      3'b101:  ext = {{(XLEN-16){1'b0}}, half_v};
      default: ext = '0;
    endcase

    illegal = (cur_f3 == 3'b011) || (cur_f3 == 3'b110) || (cur_f3 == 3'b111);
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = (((cur_f3 == 3'b001) || (cur_f3 == 3'b101)) && cur_lane[0]) ||
               ((cur_f3 == 3'b010) && (cur_lane != 2'b00));
`else
    misalign = 1'b0;
`endif
    err_c  = illegal || misalign;
    result = (err_c || !sel_ok) ? '0 : ext;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    f3_d    = f3_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_ld_req) begin
          if ((i_src_sel == SelW'(MEM_SRC)) && (MEM_LAT != 0) && !err_c) begin
            lane_d  = i_ld_addr[1:0];
            f3_d    = i_ld_funct3;
            cnt_d   = CntW'(CntLoad);
            state_d = StWait;
          end else begin
            data_d  = result;
            err_d   = err_c;
            valid_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d  = result;
          err_d   = err_c;
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lane_q  <= '0;
      f3_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      f3_q    <= f3_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_ld_data  = data_q;
  assign o_ld_valid = valid_q;
  assign o_ld_err   = err_q;
  assign o_busy     = (state_q == StWait);

endmodule

// File: tb/tb_lsu_load_unit.sv
// Directed bench for lsu_load_unit with a cycle-level reference model.
// Five sources so that an out-of-range select (5) is expressible on the
// 3-bit select port.
module tb_lsu_load_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned N_SRC   = 5;
  localparam int unsigned MEM_SRC = 2;
  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned SelW    = $clog2(N_SRC);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req;
  logic [XLEN-1:0]       addr;
  logic [2:0]            f3;
  logic [SelW-1:0]       sel;
  logic [N_SRC*XLEN-1:0] src;
  logic [XLEN-1:0]       o_ld_data;
  logic                  o_ld_valid;
  logic                  o_ld_err;
  logic                  o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  lsu_load_unit #(
    .XLEN    (XLEN),
    .N_SRC   (N_SRC),
    .MEM_SRC (MEM_SRC),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ld_req    (req),
    .i_ld_addr   (addr),
    .i_ld_funct3 (f3),
    .i_src_sel   (sel),
    .i_src_data  (src),
    .o_ld_data   (o_ld_data),
    .o_ld_valid  (o_ld_valid),
    .o_ld_err    (o_ld_err),
    .o_busy      (o_busy)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] fn);
    logic [31:0] v;
    case (fn)
      3'd0: begin v = (w >> (8 * a)) & 32'hFF; if (v >= 32'h80) v = v - 32'h100; end
      3'd1: begin v = (w >> (16 * a[1])) & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
      3'd2: v = w;
      3'd4: v = (w >> (8 * a)) & 32'hFF;
      3'd5: v = (w >> (16 * a[1])) & 32'hFFFF;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic bit model_err(input logic [1:0] a, input logic [2:0] fn);
    bit e;
    e = (fn == 3'd3) || (fn == 3'd6) || (fn == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
    if ((fn == 3'd1 || fn == 3'd5) && a[0]) e = 1'b1;
    if (fn == 3'd2 && a != 2'd0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] src_word(input int unsigned k);
    if (k >= N_SRC) return 32'h0;
    return src[k*XLEN +: XLEN];
  endfunction

  int          edge_n = 0;
  bit          pend = 1'b0;
  int          pend_due;
  logic [1:0]  pend_a;
  logic [2:0]  pend_f3;
  logic [31:0] exp_data;
  bit          exp_valid, exp_err, exp_busy;

  always @(posedge clk) begin
    bit e;
    edge_n++;
    exp_valid = 1'b0;
    if (rst) begin
      pend     = 1'b0;
      exp_data = 32'h0;
      exp_err  = 1'b0;
    end else if (pend) begin
      if (edge_n == pend_due) begin
        exp_valid = 1'b1;
        exp_err   = 1'b0;
        exp_data  = model_ext(src_word(MEM_SRC), pend_a, pend_f3);
        pend      = 1'b0;
      end
    end else if (req) begin
      e = model_err(addr[1:0], f3);
      if (sel == MEM_SRC && !e) begin
        pend     = 1'b1;
        pend_due = edge_n + MEM_LAT;
        pend_a   = addr[1:0];
        pend_f3  = f3;
      end else begin
        exp_valid = 1'b1;
        exp_err   = e;
        exp_data  = (e || sel >= N_SRC) ? 32'h0 : model_ext(src_word(sel), addr[1:0], f3);
      end
    end
    exp_busy = pend;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'b0, o_busy}, {31'b0, exp_busy});
      chk("cyc_valid", {31'b0, o_ld_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("cyc_data", o_ld_data, exp_data);
        chk("cyc_err", {31'b0, o_ld_err}, {31'b0, exp_err});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_src(input int unsigned k, input logic [31:0] v);
    src[k*XLEN +: XLEN] = v;
  endtask

  task automatic issue(input logic [31:0] a, input logic [2:0] fn, input logic [SelW-1:0] s);
    req  = 1'b1;
    addr = a;
    f3   = fn;
    sel  = s;
  endtask

  task automatic tick();
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; f3 = '0; sel = '0; src = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_data", o_ld_data, 32'h0);
    chk("rst_valid", {31'b0, o_ld_valid}, 32'h0);
    chk("rst_err", {31'b0, o_ld_err}, 32'h0);
    chk("rst_busy", {31'b0, o_busy}, 32'h0);
    rst = 1'b0;

    set_src(0, 32'h1234_5678);
    issue(32'h0, 3'b010, 3'd0); tick();
    chk("lw_data", o_ld_data, 32'h1234_5678);
    chk("lw_valid", {31'b0, o_ld_valid}, 32'h1);

    // Memory LH; a request during WAIT must be ignored.
    set_src(2, 32'h0000_80F0);
    issue(32'h0, 3'b001, 3'd2); tick();
    chk("mem_busy1", {31'b0, o_busy}, 32'h1);
    issue(32'h0, 3'b010, 3'd0); tick();
    chk("mem_busy2", {31'b0, o_busy}, 32'h1);
    chk("mem_novalid", {31'b0, o_ld_valid}, 32'h0);
    tick();
    chk("mem_lh_data", o_ld_data, 32'hFFFF_80F0);
    chk("mem_lh_valid", {31'b0, o_ld_valid}, 32'h1);
    // New request in the cycle valid is high.
    issue(32'h2, 3'b101, 3'd0); tick();
    chk("lhu_hi", o_ld_data, 32'h0000_1234);

    set_src(1, 32'hAB00_0000);
    issue(32'h3, 3'b100, 3'd1); tick();
    chk("lbu_data", o_ld_data, 32'h0000_00AB);
    issue(32'h3, 3'b000, 3'd1); tick();
    chk("lb_data", o_ld_data, 32'hFFFF_FFAB);

    issue(32'h0, 3'b011, 3'd2); tick();
    chk("ill_data", o_ld_data, 32'h0);
    chk("ill_err", {31'b0, o_ld_err}, 32'h1);
    chk("ill_nobusy", {31'b0, o_busy}, 32'h0);

    issue(32'h0, 3'b010, 3'd5); tick();
    chk("sel5_data", o_ld_data, 32'h0);
    chk("sel5_err", {31'b0, o_ld_err}, 32'h0);
    chk("sel5_valid", {31'b0, o_ld_valid}, 32'h1);

    // Reset during WAIT drops the load.
    issue(32'h0, 3'b010, 3'd2); tick();
    chk("rw_busy", {31'b0, o_busy}, 32'h1);
    rst = 1'b1; tick();
    chk("rw_idle", {31'b0, o_busy}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rw_novalid", {31'b0, o_ld_valid}, 32'h0);
    end

    issue(32'h2, 3'b010, 3'd0); tick();
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_err", {31'b0, o_ld_err}, 32'h1);
    chk("mis_data", o_ld_data, 32'h0);
`else
    chk("mis_err", {31'b0, o_ld_err}, 32'h0);
    chk("mis_data", o_ld_data, 32'h1234_5678);
`endif

    // Memory data is sampled at the capture edge, not at request time.
    set_src(2, 32'h1122_3344);
    issue(32'h1, 3'b100, 3'd2); tick();
    set_src(2, 32'h5566_7788);
    tick(); tick();
    chk("mem_lbu_late", o_ld_data, 32'h0000_0077);

    issue(32'h1, 3'b000, 3'd0); tick();
    chk("lb_pos", o_ld_data, 32'h0000_0056);
    set_src(3, 32'h0000_8001);
    issue(32'h0, 3'b001, 3'd3); tick();
    chk("lh_neg", o_ld_data, 32'hFFFF_8001);
    set_src(4, 32'hFFFF_0000);
    issue(32'h2, 3'b101, 3'd4); tick();
    chk("lhu_top", o_ld_data, 32'h0000_FFFF);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
